// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: master mode codes,
// command-word layout and the sequencer FSM encoding.
package i2c_pkg;

  localparam logic [2:0] I2C_WAIT           = 3'd0;
  localparam logic [2:0] I2C_SINGLE_WRITE   = 3'd1;
  localparam logic [2:0] I2C_CONT_WRITE     = 3'd2;
  localparam logic [2:0] I2C_WRITE_DIRECTLY = 3'd3;
  localparam logic [2:0] I2C_SINGLE_READ    = 3'd4;
  localparam logic [2:0] I2C_CONT_READ      = 3'd5;
  localparam logic [2:0] I2C_READ_DIRECTLY  = 3'd6;

  // Command word: {mode[2:0], dev_addr[6:0], reg_addr[7:0], wr_data[7:0]}
  localparam int CMD_W        = 26;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_REG_LSB  = 8;
  localparam int CMD_DEV_LSB  = 16;
  localparam int CMD_MODE_LSB = 23;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  function automatic logic mode_is_read(input logic [2:0] mode);
    return mode inside {I2C_SINGLE_READ, I2C_CONT_READ, I2C_READ_DIRECTLY};
  endfunction

  function automatic logic mode_is_cmd(input logic [2:0] mode);
    return (mode inside {I2C_SINGLE_WRITE, I2C_CONT_WRITE, I2C_WRITE_DIRECTLY}) ||
           mode_is_read(mode);
  endfunction

endpackage

// File: rtl/i2c_rd_buf.sv
// Read-data buffer: simple dual-port RAM, one write port from the sequencer
// and one registered read port for the application.
module i2c_rd_buf #(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d, rd_data_q;

  // NOTE: the storage array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb rd_data_d = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks an external I2C command table, drives i2c_master_logic one command at a
// time, retries failed commands and collects read bytes into a local buffer.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_CMDS       = 16,
  parameter int RD_BUF_DEPTH   = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RETRY_GAP      = 1200,
  localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
  localparam int BUF_W = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1
) (
  input  logic             clk_12m,
  input  logic             rst_n,
  input  logic             run,
  output logic [IDX_W-1:0] cmd_idx,
  input  logic [CMD_W-1:0] cmd_word,
  output logic [7:0]       i2c_config,
  output logic [6:0]       i2c_dev_addr,
  output logic [7:0]       i2c_reg_addr,
  output logic [7:0]       i2c_reg_data,
  output logic             i2c_start,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  input  logic [7:0]       i2c_read_data,
  output logic             busy,
  output logic             seq_done,
  output logic             seq_err,
  output logic [IDX_W-1:0] err_idx,
  output logic [BUF_W:0]   rd_count,
  input  logic [BUF_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W    = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;
  localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_LAST = (RETRY_GAP > 0) ? RETRY_GAP - 1 : 0;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CMDS - 1);
  localparam logic [BUF_W:0]   BUF_FULL  = (BUF_W + 1)'(RD_BUF_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_LAST);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

  logic [2:0]       state_d,    state_q;
  logic [IDX_W-1:0] cmd_idx_d,  cmd_idx_q;
  logic [IDX_W-1:0] err_idx_d,  err_idx_q;
  logic [BUF_W:0]   rd_count_d, rd_count_q;
  logic [RTY_W-1:0] retry_d,    retry_q;
  logic [TO_W-1:0]  timeout_d,  timeout_q;
  logic [GAP_W-1:0] gap_d,      gap_q;
  logic [7:0]       config_d,   config_q;
  logic [6:0]       dev_d,      dev_q;
  logic [7:0]       reg_d,      reg_q;
  logic [7:0]       data_d,     data_q;
  logic             buf_wr_en;

  logic [2:0] cmd_mode;
  assign cmd_mode = cmd_word[CMD_MODE_LSB +: 3];

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    err_idx_d  = err_idx_q;
    rd_count_d = rd_count_q;
    retry_d    = retry_q;
    timeout_d  = timeout_q;
    gap_d      = gap_q;
    config_d   = config_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    data_d     = data_q;
    buf_wr_en  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (run) begin
          cmd_idx_d  = '0;
          rd_count_d = '0;
          retry_d    = '0;
          err_idx_d  = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        config_d = {5'b0, cmd_mode};
        dev_d    = cmd_word[CMD_DEV_LSB +: 7];
        reg_d    = cmd_word[CMD_REG_LSB +: 8];
        data_d   = cmd_word[CMD_DATA_LSB +: 8];
        if (cmd_mode == I2C_WAIT) begin
          state_d = ST_DONE;
        end else if (!mode_is_cmd(cmd_mode)) begin
          err_idx_d = cmd_idx_q;
          state_d   = ST_ERROR;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        timeout_d = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        timeout_d = timeout_q + 1'b1;
        // A done on the expiry cycle wins over the timeout.
        if (i2c_done && !i2c_nack) begin
          if (mode_is_read(config_q[2:0]) && (rd_count_q < BUF_FULL)) begin
            buf_wr_en  = 1'b1;
            rd_count_d = rd_count_q + 1'b1;
          end
          retry_d = '0;
          if (cmd_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cmd_idx_d = cmd_idx_q + 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (i2c_done || (timeout_q == TO_LAST)) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            err_idx_d = cmd_idx_q;
            state_d   = ST_ERROR;
          end
        end
      end

      ST_GAP: begin
        if (gap_q >= GAP_END) state_d = ST_ISSUE;
        else                  gap_d   = gap_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_idx_q  <= '0;
      err_idx_q  <= '0;
      rd_count_q <= '0;
      retry_q    <= '0;
      timeout_q  <= '0;
      gap_q      <= '0;
      config_q   <= '0;
      dev_q      <= '0;
      reg_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      err_idx_q  <= err_idx_d;
      rd_count_q <= rd_count_d;
      retry_q    <= retry_d;
      timeout_q  <= timeout_d;
      gap_q      <= gap_d;
      config_q   <= config_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
    end
  end

  i2c_rd_buf #(
    .DEPTH (RD_BUF_DEPTH)
  ) u_rd_buf (
    .clk     (clk_12m),
    .rst_n   (rst_n),
    .wr_en   (buf_wr_en),
    .wr_addr (rd_count_q[BUF_W-1:0]),
    .wr_data (i2c_read_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign cmd_idx      = cmd_idx_q;
  assign err_idx      = err_idx_q;
  assign rd_count     = rd_count_q;
  assign i2c_config   = config_q;
  assign i2c_dev_addr = dev_q;
  assign i2c_reg_addr = reg_q;
  assign i2c_reg_data = data_q;
  assign i2c_start    = (state_q == ST_ISSUE);
  assign busy         = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign seq_done     = (state_q == ST_DONE);
  assign seq_err      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: an I2C master model answers each
// start, and a table-level reference model predicts the outcome of every run.
module tb_i2c_cmd_sequencer;

  localparam int NUM_CMDS       = 4;
  localparam int RD_BUF_DEPTH   = 2;
  localparam int MAX_RETRY      = 3;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int RETRY_GAP      = 20;
  localparam int IDX_W          = 2;
  localparam int BUF_W          = 1;
  localparam int BUDGET         = 5000;
  localparam int PERM           = 255;

  logic             clk_12m = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [IDX_W-1:0] cmd_idx;
  logic [25:0]      cmd_word;
  logic [7:0]       i2c_config;
  logic [6:0]       i2c_dev_addr;
  logic [7:0]       i2c_reg_addr;
  logic [7:0]       i2c_reg_data;
  logic             i2c_start;
  logic             i2c_done;
  logic             i2c_nack = 1'b0;
  logic [7:0]       i2c_read_data = 8'h00;
  logic             busy, seq_done, seq_err;
  logic [IDX_W-1:0] err_idx;
  logic [BUF_W:0]   rd_count;
  logic [BUF_W-1:0] rd_addr = '0;
  logic [7:0]       rd_data;

  logic m_done = 1'b0;
  logic stray_done = 1'b0;
  assign i2c_done = m_done | stray_done;

  // Command table and per-entry master behaviour
  logic [25:0] tbl [NUM_CMDS];
  int          nack_cnt [NUM_CMDS];
  bit          silent [NUM_CMDS];
  int          lat [NUM_CMDS];
  logic [7:0]  rdata [NUM_CMDS];
  int          att [NUM_CMDS];

  assign cmd_word = tbl[cmd_idx];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int field_bad = 0;
  int st_idx_q [$];
  int st_cyc_q [$];
  int mi;

  // Reference-model results
  bit         exp_err;
  int         exp_err_idx;
  int         exp_cnt;
  logic [7:0] exp_buf [RD_BUF_DEPTH];
  int         exp_starts [NUM_CMDS];

  i2c_cmd_sequencer #(
    .NUM_CMDS       (NUM_CMDS),
    .RD_BUF_DEPTH   (RD_BUF_DEPTH),
    .MAX_RETRY      (MAX_RETRY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .RETRY_GAP      (RETRY_GAP)
  ) dut (
    .clk_12m       (clk_12m),
    .rst_n         (rst_n),
    .run           (run),
    .cmd_idx       (cmd_idx),
    .cmd_word      (cmd_word),
    .i2c_config    (i2c_config),
    .i2c_dev_addr  (i2c_dev_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_reg_data  (i2c_reg_data),
    .i2c_start     (i2c_start),
    .i2c_done      (i2c_done),
    .i2c_nack      (i2c_nack),
    .i2c_read_data (i2c_read_data),
    .busy          (busy),
    .seq_done      (seq_done),
    .seq_err       (seq_err),
    .err_idx       (err_idx),
    .rd_count      (rd_count),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clk_12m = ~clk_12m;
  always @(posedge clk_12m) cyc <= cyc + 1;

  // Master model: logs each start, checks the presented fields, answers after lat cycles.
  initial begin
    forever begin
      @(negedge clk_12m);
      if (i2c_start === 1'b1) begin
        mi = int'(cmd_idx);
        st_idx_q.push_back(mi);
        st_cyc_q.push_back(cyc);
        if ({i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data} !== {5'b0, tbl[mi]})
          field_bad++;
        if (!silent[mi]) begin
          repeat (lat[mi]) @(negedge clk_12m);
          i2c_nack      = (att[mi] < nack_cnt[mi]);
          att[mi]++;
          i2c_read_data = rdata[mi];
          m_done        = 1'b1;
          @(negedge clk_12m);
          m_done        = 1'b0;
          i2c_nack      = 1'b0;
          i2c_read_data = 8'($urandom);
        end
      end
    end
  end

  function automatic logic [25:0] mk(input int mode, input int dev, input int rg, input int dat);
    return {3'(mode), 7'(dev), 8'(rg), 8'(dat)};
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < NUM_CMDS; i++) begin
      tbl[i] = '0; nack_cnt[i] = 0; silent[i] = 1'b0; lat[i] = 2; rdata[i] = 8'h00;
    end
  endtask

  // Table-level prediction: walk entries, count attempts, collect read bytes.
  task automatic model_run();
    int fails;
    logic [2:0] m;
    exp_err = 1'b0; exp_err_idx = 0; exp_cnt = 0;
    for (int i = 0; i < NUM_CMDS; i++) exp_starts[i] = 0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      m = tbl[i][25:23];
      if (m == 3'd0) return;
      if (m == 3'd7) begin exp_err = 1'b1; exp_err_idx = i; return; end
      fails = silent[i] ? MAX_RETRY + 1 : nack_cnt[i];
      if (fails > MAX_RETRY) begin
        exp_starts[i] = MAX_RETRY + 1; exp_err = 1'b1; exp_err_idx = i; return;
      end
      exp_starts[i] = fails + 1;
      if (m >= 3'd4 && exp_cnt < RD_BUF_DEPTH) begin
        exp_buf[exp_cnt] = rdata[i];
        exp_cnt++;
      end
    end
  endtask

  task automatic pulse_run();
    st_idx_q.delete();
    st_cyc_q.delete();
    field_bad = 0;
    for (int i = 0; i < NUM_CMDS; i++) att[i] = 0;
    @(negedge clk_12m); run = 1'b1;
    @(negedge clk_12m); run = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(seq_done || seq_err) && n < BUDGET) begin
      @(negedge clk_12m);
      n++;
    end
    n_checks++;
    if (seq_done || seq_err) n_pass++;
    else $display("FAIL %s completion: not finished after %0d cycles, required DONE or ERROR", name, BUDGET);
  endtask

  task automatic read_buf(input int a, output logic [7:0] d);
    @(negedge clk_12m); rd_addr = BUF_W'(a);
    @(negedge clk_12m); d = rd_data;
  endtask

  task automatic verify_run(input string name);
    int starts [NUM_CMDS];
    int gap_bad = 0;
    logic [7:0] d;
    model_run();
    for (int i = 0; i < NUM_CMDS; i++) starts[i] = 0;
    for (int k = 0; k < st_idx_q.size(); k++) begin
      starts[st_idx_q[k]]++;
      if (k > 0 && st_idx_q[k] == st_idx_q[k-1] && (st_cyc_q[k] - st_cyc_q[k-1]) < RETRY_GAP)
        gap_bad++;
    end
    n_checks++;
    if (seq_done !== !exp_err) $display("FAIL %s seq_done: got %b required %b", name, seq_done, !exp_err);
    else n_pass++;
    n_checks++;
    if (seq_err !== exp_err) $display("FAIL %s seq_err: got %b required %b", name, seq_err, exp_err);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy: got %b required 0", name, busy);
    else n_pass++;
    if (exp_err) begin
      n_checks++;
      if (err_idx !== IDX_W'(exp_err_idx)) $display("FAIL %s err_idx: got %0d required %0d", name, err_idx, exp_err_idx);
      else n_pass++;
    end
    n_checks++;
    if (rd_count !== (BUF_W + 1)'(exp_cnt)) $display("FAIL %s rd_count: got %0d required %0d", name, rd_count, exp_cnt);
    else n_pass++;
    for (int i = 0; i < NUM_CMDS; i++) begin
      n_checks++;
      if (starts[i] !== exp_starts[i]) $display("FAIL %s starts[%0d]: got %0d required %0d", name, i, starts[i], exp_starts[i]);
      else n_pass++;
    end
    n_checks++;
    if (field_bad !== 0) $display("FAIL %s master fields: %0d wrong starts, required 0", name, field_bad);
    else n_pass++;
    n_checks++;
    if (gap_bad !== 0) $display("FAIL %s retry gap: %0d short gaps, required 0", name, gap_bad);
    else n_pass++;
    for (int i = 0; i < exp_cnt; i++) begin
      read_buf(i, d);
      n_checks++;
      if (d !== exp_buf[i]) $display("FAIL %s buf[%0d]: got %h required %h", name, i, d, exp_buf[i]);
      else n_pass++;
    end
  endtask

  function automatic logic [56:0] all_outs();
    return {busy, seq_done, seq_err, err_idx, cmd_idx, rd_count, i2c_start,
            i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, rd_data};
  endfunction

  task automatic test_reset();
    clear_cfg();
    repeat (3) @(negedge clk_12m);
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset outputs: got %h required 0", all_outs());
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_cfg();
    tbl[0] = mk(1, 'h50, 'h00, 'hBB);
    tbl[1] = mk(4, 'h50, 'h00, 'h00);
    tbl[2] = mk(0, 0, 0, 0);
    rdata[1] = 8'hA5;
    pulse_run();
    n_checks++;
    if (i2c_start !== 1'b0) $display("FAIL basic start_latency1: got %b required 0", i2c_start);
    else n_pass++;
    @(negedge clk_12m);
    n_checks++;
    if (i2c_start !== 1'b1) $display("FAIL basic start_latency2: got %b required 1", i2c_start);
    else n_pass++;
    wait_end("basic");
    verify_run("basic");
  endtask

  task automatic test_retry();
    clear_cfg();
    tbl[0] = mk(2, 'h68, 'h6B, 'h00);
    tbl[1] = mk(5, 'h68, 'h3B, 'h00);
    nack_cnt[0] = 2;
    rdata[1] = 8'h3C;
    pulse_run();
    wait_end("retry");
    verify_run("retry");
  endtask

  task automatic test_perm_nack();
    clear_cfg();
    tbl[0] = mk(1, 'h50, 'h01, 'h11);
    tbl[1] = mk(3, 'h50, 'h02, 'h22);
    tbl[2] = mk(1, 'h51, 'h03, 'h33);
    nack_cnt[2] = PERM;
    pulse_run();
    wait_end("perm_nack");
    verify_run("perm_nack");
    nack_cnt[2] = 0;
    pulse_run();
    n_checks++;
    if ({seq_err, err_idx, cmd_idx} !== '0) $display("FAIL rerun clear: got err=%b idx=%0d cmd=%0d required 0/0/0", seq_err, err_idx, cmd_idx);
    else n_pass++;
    wait_end("rerun");
    verify_run("rerun");
  endtask

  task automatic test_timeout();
    clear_cfg();
    tbl[0] = mk(6, 'h50, 'h10, 'h00);
    tbl[1] = mk(1, 'h50, 'h11, 'h44);
    silent[0] = 1'b1;
    pulse_run();
    wait_end("timeout");
    verify_run("timeout");
    for (int k = 1; k < st_cyc_q.size(); k++) begin
      n_checks++;
      if (st_cyc_q[k] - st_cyc_q[k-1] !== TIMEOUT_CYCLES + RETRY_GAP + 1)
        $display("FAIL timeout spacing[%0d]: got %0d required %0d", k, st_cyc_q[k] - st_cyc_q[k-1], TIMEOUT_CYCLES + RETRY_GAP + 1);
      else n_pass++;
    end
    // done arriving on the expiry cycle
    silent[0] = 1'b0;
    lat[0] = TIMEOUT_CYCLES;
    rdata[0] = 8'h5E;
    pulse_run();
    wait_end("done_at_timeout");
    verify_run("done_at_timeout");
  endtask

  task automatic test_buf_sat();
    clear_cfg();
    tbl[0] = mk(4, 'h50, 'h00, 0); rdata[0] = 8'h11;
    tbl[1] = mk(5, 'h50, 'h01, 0); rdata[1] = 8'h22;
    tbl[2] = mk(6, 'h50, 'h02, 0); rdata[2] = 8'h33;
    pulse_run();
    wait_end("buf_sat");
    verify_run("buf_sat");
  endtask

  task automatic test_no_marker();
    clear_cfg();
    for (int i = 0; i < NUM_CMDS; i++) tbl[i] = mk(1 + (i % 3), 'h20 + i, i, 'h90 + i);
    pulse_run();
    wait_end("no_marker");
    verify_run("no_marker");
  endtask

  task automatic test_illegal();
    clear_cfg();
    tbl[0] = mk(1, 'h50, 'h00, 'h01);
    tbl[1] = mk(7, 'h50, 'h00, 'h02);
    pulse_run();
    wait_end("illegal");
    verify_run("illegal");
  endtask

  task automatic test_run_in_wait();
    clear_cfg();
    tbl[0] = mk(1, 'h50, 'h00, 'h77);
    tbl[1] = mk(4, 'h50, 'h01, 'h00);
    lat[0] = 30;
    rdata[1] = 8'hC3;
    pulse_run();
    repeat (6) @(negedge clk_12m);
    run = 1'b1;
    @(negedge clk_12m);
    run = 1'b0;
    n_checks++;
    if ({busy, cmd_idx} !== {1'b1, 2'd0}) $display("FAIL run_in_wait state: got busy=%b idx=%0d required 1/0", busy, cmd_idx);
    else n_pass++;
    wait_end("run_in_wait");
    verify_run("run_in_wait");
  endtask

  task automatic test_reset_in_wait();
    clear_cfg();
    tbl[0] = mk(2, 'h50, 'h0F, 'hEE);
    silent[0] = 1'b1;
    pulse_run();
    repeat (8) @(negedge clk_12m);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_in_wait outputs: got %h required 0", all_outs());
    else n_pass++;
    repeat (3) @(posedge clk_12m);
    #1;
    n_checks++;
    if ({busy, i2c_start} !== 2'b00) $display("FAIL reset_in_wait held: got busy/start=%b required 00", {busy, i2c_start});
    else n_pass++;
    @(negedge clk_12m);
    rst_n = 1'b1;
    silent[0] = 1'b0;
    pulse_run();
    wait_end("after_reset");
    verify_run("after_reset");
  endtask

  task automatic test_stray_done();
    logic [BUF_W:0] cnt_before;
    cnt_before = rd_count;
    @(negedge clk_12m);
    i2c_read_data = 8'hF0;
    stray_done = 1'b1;
    @(negedge clk_12m);
    stray_done = 1'b0;
    repeat (2) @(negedge clk_12m);
    n_checks++;
    if ({seq_done, busy, rd_count} !== {1'b1, 1'b0, cnt_before})
      $display("FAIL stray_done: got done=%b busy=%b cnt=%0d required 1/0/%0d", seq_done, busy, rd_count, cnt_before);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 8; it++) begin
      clear_cfg();
      for (int i = 0; i < NUM_CMDS; i++) begin
        r = $urandom_range(0, 9);
        tbl[i] = mk((r == 0) ? 0 : (r == 1) ? 7 : $urandom_range(1, 6),
                    $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 255));
        r = $urandom_range(0, 9);
        nack_cnt[i] = (r < 5) ? 0 : (r < 9) ? $urandom_range(1, MAX_RETRY) : MAX_RETRY + 1;
        silent[i] = ($urandom_range(0, 11) == 0);
        lat[i] = $urandom_range(1, 8);
        rdata[i] = 8'($urandom);
      end
      pulse_run();
      wait_end($sformatf("random%0d", it));
      verify_run($sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stray_done();
    test_retry();
    test_perm_nack();
    test_timeout();
    test_buf_sat();
    test_no_marker();
    test_illegal();
    test_run_in_wait();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Parametrised I2C transaction sequencer that replaces the hard-wired write-then-read configuration FSM. It walks an external command table of up to NUM_CMDS entries and drives i2c_master_logic one command at a time through a start/done handshake. It retries NACKed or timed-out commands, stores read bytes in an internal buffer, and reports completion or error with the index of the failing command. It sits between the top-level application (for example the MPU6050/AT24C02 init and polling logic) and i2c_master_logic.

Parameters:
NUM_CMDS, 16, command table depth; the index is IDX_W = clog2(NUM_CMDS) bits.
RD_BUF_DEPTH, 8, number of read-data buffer entries; the buffer address is BUF_W = clog2(RD_BUF_DEPTH) bits.
MAX_RETRY, 3, maximum re-issues per command after a failure (0 means no retry).
TIMEOUT_CYCLES, 65535, clk_12m cycles to wait for i2c_done before the attempt counts as failed.
RETRY_GAP, 1200, idle clk_12m cycles between a failure and the re-issue (100 us at 12 MHz).

Ports:
clk_12m  in  1  system clock, 12 MHz.
rst_n  in  1  asynchronous active-low reset.
run  in  1  single-cycle pulse; starts table execution at index 0. Ignored unless the sequencer is in IDLE, DONE or ERROR.
cmd_idx  out  IDX_W  current table index; the external table returns its entry combinationally.
cmd_word  in  26  table entry as {mode[2:0], dev_addr[6:0], reg_addr[7:0], wr_data[7:0]}.
i2c_config  out  8  mode code sent to the master: 1 single write, 2 continuous write, 3 write directly, 4 single read, 5 continuous read, 6 read directly.
i2c_dev_addr  out  7  device address to the master.
i2c_reg_addr  out  8  register address to the master.
i2c_reg_data  out  8  write data to the master.
i2c_start  out  1  single-cycle pulse requesting a transaction.
i2c_done  in  1  single-cycle pulse from the master marking end of transaction, synchronous to clk_12m.
i2c_nack  in  1  qualified by i2c_done; 1 means a NACK was received.
i2c_read_data  in  8  read byte, valid when i2c_done is high.
busy  out  1  high in any state other than IDLE, DONE and ERROR.
seq_done  out  1  high while in DONE.
seq_err  out  1  high while in ERROR.
err_idx  out  IDX_W  index of the failing command; valid while seq_err is high.
rd_count  out  BUF_W+1  number of bytes stored during the current run.
rd_addr  in  BUF_W  buffer read address.
rd_data  out  8  buffer content at rd_addr, registered with 1-cycle latency.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and all counters are cleared. Buffer contents are don't-care after reset.
- Reset mid-operation: the FSM aborts immediately and i2c_start is low from the reset edge onward. Recovering the bus is the master's responsibility.
- State machine states: IDLE, FETCH, ISSUE, WAIT, GAP, DONE, ERROR.
- IDLE/DONE/ERROR, on run: cmd_idx <= 0, rd_count <= 0, retry counter <= 0, next state FETCH. seq_done, seq_err and err_idx clear on the same edge.
- FETCH: register cmd_word fields into i2c_config, i2c_dev_addr, i2c_reg_addr and i2c_reg_data.
  - mode == 0 is the end-of-table marker: go to DONE.
  - mode == 7 is illegal: go to ERROR with err_idx = cmd_idx.
  - Otherwise go to ISSUE.
- ISSUE: assert i2c_start for exactly one cycle, clear the timeout counter, go to WAIT. i2c_start therefore rises 2 cycles after the run pulse.
- WAIT: increment the timeout counter each cycle.
  - i2c_done && !i2c_nack: success.
  - i2c_done && i2c_nack, or the counter reaching TIMEOUT_CYCLES-1 without i2c_done: failure.
  - i2c_done arriving on the same cycle the timeout expires counts as done; done has priority.
- Success:
  - For modes 4, 5 and 6, write i2c_read_data into buf[rd_count] and increment rd_count.
  - If rd_count == RD_BUF_DEPTH, the byte is dropped, rd_count saturates, and the run still succeeds.
  - Then clear the retry counter.
  - If cmd_idx == NUM_CMDS-1, go to DONE (implicit end). Otherwise increment cmd_idx and go to FETCH.
- Failure: if the retry counter < MAX_RETRY, increment it and go to GAP. Otherwise set err_idx = cmd_idx and go to ERROR.
- GAP: count RETRY_GAP cycles, then go to ISSUE. The same command is re-issued; cmd_idx is unchanged.
- Mode 5 (continuous read) is treated as one transaction that returns one byte per i2c_done. Multi-byte bursts are outside this block's scope.
- DONE and ERROR hold until the next run. The buffer stays readable in these states; rd_data is valid in all states.
- Stray i2c_done outside WAIT is ignored.
- i2c_config, i2c_dev_addr, i2c_reg_addr and i2c_reg_data are stable from FETCH through the end of WAIT.

Decomposition:
- Shared package i2c_pkg holds:
  - mode code constants: I2C_WAIT = 0 through I2C_READ_DIRECTLY = 6;
  - command field offsets and CMD_W = 26;
  - the FSM state encoding.
- One sub-module, i2c_rd_buf: a simple dual-port RAM with RD_BUF_DEPTH x 8 entries, a registered read port, and write enable and address driven by the sequencer.

Test Plan:
1. Table {1,0x50,0x00,0xBB}, {4,0x50,0x00,-}, {0}; master model ACKs and returns 0xA5 on the read -> exactly two i2c_start pulses, seq_done = 1, rd_count = 1, buffer[0] = 0xA5.
2. First command NACKed twice, then ACKed, with MAX_RETRY = 3 -> three i2c_start pulses on index 0, each re-issue separated by ≥ RETRY_GAP cycles, then normal completion.
3. Command 2 NACKs permanently -> MAX_RETRY+1 starts on index 2, then seq_err = 1 and err_idx = 2; a subsequent run clears seq_err and restarts at index 0.
4. Master never returns i2c_done -> failure after TIMEOUT_CYCLES cycles (bench sets TIMEOUT_CYCLES = 100), retries follow, then ERROR; also check i2c_done and timeout on the same cycle are treated as success.
5. RD_BUF_DEPTH = 2 with three read commands returning 0x11, 0x22, 0x33 -> rd_count = 2, buffer = {0x11, 0x22}, seq_done = 1.
6. run pulsed during WAIT is ignored; rst_n asserted during WAIT gives all outputs 0 and IDLE immediately; NUM_CMDS = 4 with no 0-marker -> DONE after index 3.
